// File: rtl/branch_resolve_bht.sv
// Branch resolve unit with a direct-mapped 2-bit BHT and resolve/mispredict statistics.
// Operands are compared at full XLEN; results are registered single-cycle pulses.
module branch_resolve_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_pred_taken,
  input  logic             stat_clear,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_illegal,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_bht [BHT_DEPTH];
  logic             r_resValid;
  logic             r_resTaken;
  logic             r_resMispredict;
  logic             r_resIllegal;
  logic [CNT_W-1:0] r_statBranches;
  logic [CNT_W-1:0] r_statMispredicts;

  logic [IDX_W-1:0] w_ifIdx;
  logic [IDX_W-1:0] w_exIdx;
  logic             w_eq;
  logic             w_slt;
  logic             w_ult;
  logic             w_cond;
  logic             w_illegal;
  logic             w_update;
  logic             w_mispredict;
  logic [1:0]       w_ctrCur;
  logic [1:0]       w_ctrNext;
  logic             w_unused;

  // Only the word-aligned index bits address the table; higher PC bits alias.
  assign w_ifIdx  = if_pc[IDX_W+1:2];
  assign w_exIdx  = ex_pc[IDX_W+1:2];
  assign w_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign w_eq  = (ex_rs1 == ex_rs2);
  assign w_slt = ($signed(ex_rs1) < $signed(ex_rs2));
  assign w_ult = (ex_rs1 < ex_rs2);

  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (ex_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_slt;
      3'b101:  w_cond = !w_slt;
      3'b110:  w_cond = w_ult;
      3'b111:  w_cond = !w_ult;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_update     = ex_valid && !w_illegal;
  assign w_mispredict = w_cond ^ ex_pred_taken;
  assign w_ctrCur     = r_bht[w_exIdx];

  // Saturating 2-bit counter step toward the resolved direction.
  always_comb begin
    w_ctrNext = w_ctrCur;
    if (w_cond) begin
      if (w_ctrCur != 2'b11) w_ctrNext = w_ctrCur + 2'd1;
    end else begin
      if (w_ctrCur != 2'b00) w_ctrNext = w_ctrCur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resValid        <= 1'b0;
      r_resTaken        <= 1'b0;
      r_resMispredict   <= 1'b0;
      r_resIllegal      <= 1'b0;
      r_statBranches    <= '0;
      r_statMispredicts <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else begin
      r_resValid      <= ex_valid;
      r_resTaken      <= w_update && w_cond;
      r_resMispredict <= w_update && w_mispredict;
      r_resIllegal    <= ex_valid && w_illegal;
      if (w_update) r_bht[w_exIdx] <= w_ctrNext;
      // A clear wins over any increment arriving in the same cycle.
      if (stat_clear) begin
        r_statBranches    <= '0;
        r_statMispredicts <= '0;
      end else if (w_update) begin
        r_statBranches <= r_statBranches + CNT_ONE;
        if (w_mispredict) r_statMispredicts <= r_statMispredicts + CNT_ONE;
      end
    end
  end

  assign if_pred_taken    = r_bht[w_ifIdx][1];
  assign res_valid        = r_resValid;
  assign res_taken        = r_resTaken;
  assign res_mispredict   = r_resMispredict;
  assign res_illegal      = r_resIllegal;
  assign stat_branches    = r_statBranches;
  assign stat_mispredicts = r_statMispredicts;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Randomised self-checking bench for branch_resolve_bht against a behavioural model.
// A second instance with 4-bit statistics counters exercises counter wrap.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_pred_taken;
  logic        stat_clear;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic        res_illegal;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  logic        s_if_pred_taken;
  logic        s_res_valid;
  logic        s_res_taken;
  logic        s_res_mispredict;
  logic        s_res_illegal;
  logic [3:0]  s_stat_branches;
  logic [3:0]  s_stat_mispredicts;

  int numChecks = 0;
  int numFails  = 0;

  // Reference state: counter values 0..3 per entry and plain integer statistics.
  int          mBht [64];
  int unsigned mBranches;
  int unsigned mMispredicts;

  always #5 clk = ~clk;

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_pred_taken(ex_pred_taken), .stat_clear(stat_clear),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_illegal(res_illegal), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(s_if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_pred_taken(ex_pred_taken), .stat_clear(stat_clear),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_mispredict(s_res_mispredict),
    .res_illegal(s_res_illegal), .stat_branches(s_stat_branches),
    .stat_mispredicts(s_stat_mispredicts)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit branchTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int    sa = int'(a);
    int    sb = int'(b);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  // One clock of stimulus: lookup checked before the edge, results after it.
  task automatic applyStimulus(input bit rstI, input bit validI, input logic [31:0] pcI,
                               input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                               input bit predI, input bit clrI, input logic [31:0] ifPcI);
    bit expV, expT, expM, expI, legal, cond;
    rst = rstI; ex_valid = validI; ex_pc = pcI; ex_rs1 = a; ex_rs2 = b;
    ex_funct3 = f3; ex_pred_taken = predI; stat_clear = clrI; if_pc = ifPcI;
    #1;
    if (!rstI) begin
      checkOutput("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, mBht[idxOf(ifPcI)] >= 2});
      checkOutput("small_if_pred", {31'd0, s_if_pred_taken}, {31'd0, mBht[idxOf(ifPcI)] >= 2});
    end
    @(posedge clk);
    #1;
    expV = 0; expT = 0; expM = 0; expI = 0;
    if (rstI) begin
      for (int i = 0; i < 64; i++) mBht[i] = 1;
      mBranches = 0;
      mMispredicts = 0;
    end else begin
      legal = (f3 != 3'd2) && (f3 != 3'd3);
      cond  = legal ? branchTaken(f3, a, b) : 1'b0;
      if (validI) begin
        expV = 1;
        if (legal) begin
          expT = cond;
          expM = cond != predI;
          if (cond) mBht[idxOf(pcI)] = (mBht[idxOf(pcI)] < 3) ? mBht[idxOf(pcI)] + 1 : 3;
          else      mBht[idxOf(pcI)] = (mBht[idxOf(pcI)] > 0) ? mBht[idxOf(pcI)] - 1 : 0;
          mBranches++;
          if (expM) mMispredicts++;
        end else begin
          expI = 1;
        end
      end
      if (clrI) begin
        mBranches = 0;
        mMispredicts = 0;
      end
    end
    checkOutput("res_valid", {31'd0, res_valid}, {31'd0, expV});
    checkOutput("res_taken", {31'd0, res_taken}, {31'd0, expT});
    checkOutput("res_mispredict", {31'd0, res_mispredict}, {31'd0, expM});
    checkOutput("res_illegal", {31'd0, res_illegal}, {31'd0, expI});
    checkOutput("stat_branches", stat_branches, mBranches);
    checkOutput("stat_mispredicts", stat_mispredicts, mMispredicts);
    checkOutput("small_stat_branches", {28'd0, s_stat_branches}, mBranches % 16);
    checkOutput("small_stat_mispredicts", {28'd0, s_stat_mispredicts}, mMispredicts % 16);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] pc, ifp, a, b;
    rst = 1'b1; ex_valid = 0; ex_pc = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_funct3 = 0; ex_pred_taken = 0; stat_clear = 0; if_pc = 0;
    for (int i = 0; i < 64; i++) mBht[i] = 1;
    mBranches = 0;
    mMispredicts = 0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    // beq equal with not-taken prediction; lookup of the same index shows the old value
    applyStimulus(0, 1, 32'h100, 5, 5, 3'd0, 0, 0, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);

    applyStimulus(0, 1, 32'h200, 32'hFFFF_FFFF, 1, 3'd4, 0, 0, 32'h200);
    applyStimulus(0, 1, 32'h200, 32'hFFFF_FFFF, 1, 3'd6, 1, 0, 32'h200);
    applyStimulus(0, 1, 32'h200, 32'hFFFF_FFFF, 1, 3'd5, 0, 0, 32'h200);
    applyStimulus(0, 1, 32'h200, 32'hFFFF_FFFF, 1, 3'd7, 0, 0, 32'h200);

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h40, 7, 7, 3'd0, 1, 0, 32'h40);
    applyStimulus(0, 1, 32'h40, 7, 8, 3'd0, 1, 0, 32'h40);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h40, 7, 8, 3'd0, 0, 0, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    checkOutput("sat_low_pred", {31'd0, if_pred_taken}, 32'd0);

    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 32'h40, 3, 3, 3'd0, 0, 0, 32'h140);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h140);

    applyStimulus(0, 1, 32'h40, 3, 3, 3'd2, 1, 0, 32'h40);
    applyStimulus(0, 1, 32'h44, 3, 4, 3'd3, 0, 0, 32'h44);
    applyStimulus(0, 1, 32'h48, 3, 3, 3'd0, 0, 1, 32'h48);

    applyStimulus(1, 1, 32'h48, 3, 3, 3'd0, 0, 1, 32'h48);
    for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'(i * 4));
    // Entries must be 01 after reset: one taken step flips the prediction.
    applyStimulus(0, 1, 32'h10, 0, 0, 3'd0, 1, 0, 32'h10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h10);
    checkOutput("reset_entry_01", {31'd0, if_pred_taken}, 32'd1);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 32'h80, 1, 2, 3'd1, 1, 0, 32'h80);
    checkOutput("wrap_small_branches", {28'd0, s_stat_branches}, 32'd0);
    checkOutput("wrap_wide_branches", stat_branches, 32'd16);

    for (int n = 0; n < 3000; n++) begin
      pc  = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 15) << 2);
      ifp = ($urandom_range(0, 1) == 1) ? pc : (($urandom_range(0, 7) << 8) | ($urandom_range(0, 15) << 2));
      a   = pickOperand();
      b   = ($urandom_range(0, 3) == 0) ? a : pickOperand();
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, pc, a, b,
                    3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 49) == 0, ifp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
